// File: rtl/sec_decoder_pipe.sv
// sec_decoder_pipe: two-stage single-error-correcting decoder with
// valid/ready flow control and saturating correction/uncorrectable counters.
// Optional macro SEC_KEYLOCK_EN adds a shift-register data key (key_sin/key_shift).
module sec_decoder_pipe #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CHK_W-1:0]  chk_in,
  input  logic              chk_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  input  logic              cnt_clr
`ifdef SEC_KEYLOCK_EN
  ,
  input  logic              key_sin,
  input  logic              key_shift
`endif
);

  // Parameter legality checked at elaboration.
  if (DATA_W < 4 || DATA_W > 64) begin : g_bad_data_w
    $error("sec_decoder_pipe: DATA_W must be within 4..64");
  end
  if (DATA_W > (1 << CHK_W) - CHK_W - 1) begin : g_bad_chk_w
    $error("sec_decoder_pipe: CHK_W too small for DATA_W");
  end

  // Column codes: ascending integers >= 3 that are not powers of two.
  function automatic logic [DATA_W-1:0][CHK_W-1:0] gen_cols();
    logic [DATA_W-1:0][CHK_W-1:0] c;
    int n;
    c = '0;
    n = 0;
    for (int v = 3; v < (1 << CHK_W); v++) begin
      if (n < DATA_W && (v & (v - 1)) != 0) begin
        c[n] = CHK_W'(v);
        n++;
      end
    end
    return c;
  endfunction

  localparam logic [DATA_W-1:0][CHK_W-1:0] COLS = gen_cols();

  logic [DATA_W-1:0] key_reg;

`ifdef SEC_KEYLOCK_EN
  // Key shift register: shifts left with key_sin entering bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_reg <= '0;
    end else if (key_shift) begin
      key_reg <= {key_reg[DATA_W-2:0], key_sin};
    end
  end
`else
  assign key_reg = '0;
`endif

  logic              advance;
  logic [DATA_W-1:0] kdata_c;
  logic [CHK_W-1:0]  par_c;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_chk_en;
  logic [CHK_W-1:0]  s1_syn;

  logic [DATA_W-1:0] flip_c;
  logic [DATA_W-1:0] fixed_c;
  logic              hit_c;
  logic              pow2_c;
  logic              corr_c;
  logic              uncorr_c;

  // Both stages move together whenever the output slot is free or draining.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign kdata_c  = data_in ^ key_reg;

  // Parity over the keyed data word, one check bit per column-code bit.
  always_comb begin
    par_c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int j = 0; j < CHK_W; j++) begin
        if (COLS[i][j]) par_c[j] = par_c[j] ^ kdata_c[i];
      end
    end
  end

  // Syndrome classification and single-bit data repair.
  always_comb begin
    flip_c = '0;
    hit_c  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (s1_syn == COLS[i]) begin
        flip_c[i] = 1'b1;
        hit_c     = 1'b1;
      end
    end
    pow2_c   = (s1_syn != '0) && ((s1_syn & (s1_syn - CHK_W'(1))) == '0);
    corr_c   = hit_c || pow2_c;
    uncorr_c = (s1_syn != '0) && !corr_c;
    fixed_c  = s1_data ^ flip_c;
  end

  // Pipeline registers; bubbles travel through just like words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_chk_en  <= 1'b0;
      s1_syn     <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
    end else if (advance) begin
      s1_valid   <= in_valid;
      s1_data    <= kdata_c;
      s1_chk_en  <= chk_en;
      s1_syn     <= chk_en ? (chk_in ^ par_c) : '0;
      out_valid  <= s1_valid;
      data_out   <= fixed_c ^ key_reg;
      err_corr   <= s1_valid && s1_chk_en && corr_c;
      err_uncorr <= s1_valid && s1_chk_en && uncorr_c;
    end
  end

  // Saturating event counters, bumped on each delivered flagged word.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (out_valid && out_ready && err_corr && corr_cnt != '1)
        corr_cnt <= corr_cnt + CNT_W'(1);
      if (out_valid && out_ready && err_uncorr && uncorr_cnt != '1)
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sec_decoder_pipe.sv
// Self-checking bench for sec_decoder_pipe: reference model computed from the
// column-code rules, scoreboard queue of expected words, counter model.
module tb_sec_decoder_pipe;

  localparam int DW  = 32;
  localparam int CW  = 6;
  localparam int NW  = 16;
  localparam int MAXC = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic [CW-1:0] chk_in;
  logic          chk_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic          err_corr;
  logic          err_uncorr;
  logic [NW-1:0] corr_cnt;
  logic [NW-1:0] uncorr_cnt;
  logic          cnt_clr;
`ifdef SEC_KEYLOCK_EN
  logic          key_sin;
  logic          key_shift;
`endif

  sec_decoder_pipe #(.DATA_W(DW), .CHK_W(CW), .CNT_W(NW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .chk_in     (chk_in),
    .chk_en     (chk_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt),
    .cnt_clr    (cnt_clr)
`ifdef SEC_KEYLOCK_EN
    ,
    .key_sin    (key_sin),
    .key_shift  (key_shift)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          c;
    logic          u;
  } exp_t;

  exp_t          q[$];
  int            cols[DW];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_popped = 0;
  int            m_corr = 0;
  int            m_uncorr = 0;
  bit            stall_prev = 1'b0;
  bit            last_acc = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_c;
  logic          held_u;
  logic [DW-1:0] key_model = '0;

  function automatic void build_cols();
    int n = 0;
    for (int v = 3; n < DW; v++) begin
      if ((v & (v - 1)) != 0) begin
        cols[n] = v;
        n++;
      end
    end
  endfunction

  function automatic logic [CW-1:0] parity(input logic [DW-1:0] d);
    logic [CW-1:0] p = '0;
    for (int i = 0; i < DW; i++)
      for (int j = 0; j < CW; j++)
        if (((cols[i] >> j) & 1) != 0) p[j] = p[j] ^ d[i];
    return p;
  endfunction

  function automatic exp_t model(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input logic en, input logic [DW-1:0] key);
    exp_t          e;
    logic [DW-1:0] dk;
    int            s;
    bit            found = 1'b0;
    dk  = d ^ key;
    s   = en ? int'(c ^ parity(dk)) : 0;
    e.c = 1'b0;
    e.u = 1'b0;
    if (s != 0) begin
      if ((s & (s - 1)) == 0) begin
        e.c = 1'b1;
      end else begin
        for (int i = 0; i < DW; i++) begin
          if (cols[i] == s) begin
            dk[i] = ~dk[i];
            found = 1'b1;
          end
        end
        if (found) e.c = 1'b1;
        else e.u = 1'b1;
      end
    end
    e.d = dk ^ key;
    return e;
  endfunction

  // One clock: observe at negedge+1, score, then advance to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    last_acc = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_corr = 0;
      m_uncorr = 0;
      stall_prev = 1'b0;
      key_model = '0;
    end else begin
      n_checks++;
      if (corr_cnt !== NW'(m_corr)) begin
        n_fail++;
        $display("FAIL corr_cnt: got %0d expected %0d", corr_cnt, m_corr);
      end
      n_checks++;
      if (uncorr_cnt !== NW'(m_uncorr)) begin
        n_fail++;
        $display("FAIL uncorr_cnt: got %0d expected %0d", uncorr_cnt, m_uncorr);
      end
      if (stall_prev) begin
        n_checks++;
        if ({data_out, err_corr, err_uncorr} !== {held_d, held_c, held_u}) begin
          n_fail++;
          $display("FAIL hold_stable: got %h/%b/%b expected %h/%b/%b",
                   data_out, err_corr, err_uncorr, held_d, held_c, held_u);
        end
      end
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got %h expected no word", data_out);
          end else begin
            e = q.pop_front();
            n_popped++;
            if ({data_out, err_corr, err_uncorr} !== {e.d, e.c, e.u}) begin
              n_fail++;
              $display("FAIL word: got %h c=%b u=%b expected %h c=%b u=%b",
                       data_out, err_corr, err_uncorr, e.d, e.c, e.u);
            end
            if (e.c && m_corr < MAXC) m_corr++;
            if (e.u && m_uncorr < MAXC) m_uncorr++;
          end
        end
      end else begin
        n_checks++;
        if (err_corr !== 1'b0 || err_uncorr !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_flags: got c=%b u=%b expected 0/0", err_corr, err_uncorr);
        end
      end
      if (cnt_clr) begin
        m_corr = 0;
        m_uncorr = 0;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(data_in, chk_in, chk_en, key_model));
        last_acc = 1'b1;
      end
      stall_prev = (out_valid === 1'b1) && !out_ready;
      held_d = data_out;
      held_c = err_corr;
      held_u = err_uncorr;
`ifdef SEC_KEYLOCK_EN
      if (key_shift) key_model = {key_model[DW-2:0], key_sin};
`endif
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic en);
    in_valid = 1'b1;
    data_in  = d;
    chk_in   = c;
    chk_en   = en;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (q.size() == 0 && out_valid !== 1'b1) break;
      tick();
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d words pending expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({out_valid, err_corr, err_uncorr} !== 3'b000 || data_out !== '0 ||
        corr_cnt !== '0 || uncorr_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b c=%b u=%b d=%h cc=%0d uc=%0d expected all 0",
               out_valid, err_corr, err_uncorr, data_out, corr_cnt, uncorr_cnt);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tick();
  endtask

  task automatic test_clean();
    logic [NW-1:0] c0;
    logic [NW-1:0] u0;
    c0 = corr_cnt;
    u0 = uncorr_cnt;
    out_ready = 1'b1;
    send('0, '0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_latency1: got out_valid=%b expected 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== '0 || err_corr !== 1'b0 || err_uncorr !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_word: got v=%b d=%h c=%b u=%b expected 1/0/0/0",
               out_valid, data_out, err_corr, err_uncorr);
    end
    tick();
    n_checks++;
    if (corr_cnt !== c0 || uncorr_cnt !== u0) begin
      n_fail++;
      $display("FAIL clean_counters: got %0d/%0d expected %0d/%0d", corr_cnt, uncorr_cnt, c0, u0);
    end
  endtask

  task automatic test_single_err();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    send(32'h0000_0001, '0, 1'b1);
    tick();
    n_checks++;
    if (data_out !== '0 || err_corr !== 1'b1 || err_uncorr !== 1'b0) begin
      n_fail++;
      $display("FAIL data_bit0: got d=%h c=%b u=%b expected 0/1/0", data_out, err_corr, err_uncorr);
    end
    tick();
    n_checks++;
    if (corr_cnt !== NW'(1)) begin
      n_fail++;
      $display("FAIL corr_cnt_1: got %0d expected 1", corr_cnt);
    end
    send('0, 6'h01, 1'b1);
    tick();
    n_checks++;
    if (data_out !== '0 || err_corr !== 1'b1 || err_uncorr !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_bit0: got d=%h c=%b u=%b expected 0/1/0", data_out, err_corr, err_uncorr);
    end
    tick();
    n_checks++;
    if (corr_cnt !== NW'(2)) begin
      n_fail++;
      $display("FAIL corr_cnt_2: got %0d expected 2", corr_cnt);
    end
  endtask

  task automatic test_uncorr();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    send('0, 6'h3F, 1'b1);
    tick();
    n_checks++;
    if (data_out !== '0 || err_corr !== 1'b0 || err_uncorr !== 1'b1) begin
      n_fail++;
      $display("FAIL uncorr_word: got d=%h c=%b u=%b expected 0/0/1", data_out, err_corr, err_uncorr);
    end
    tick();
    n_checks++;
    if (uncorr_cnt !== NW'(1)) begin
      n_fail++;
      $display("FAIL uncorr_cnt_1: got %0d expected 1", uncorr_cnt);
    end
    send('0, 6'h3F, 1'b0);
    tick();
    n_checks++;
    if (data_out !== '0 || err_corr !== 1'b0 || err_uncorr !== 1'b0) begin
      n_fail++;
      $display("FAIL passthru_word: got d=%h c=%b u=%b expected 0/0/0", data_out, err_corr, err_uncorr);
    end
    tick();
    n_checks++;
    if (uncorr_cnt !== NW'(1)) begin
      n_fail++;
      $display("FAIL uncorr_cnt_hold: got %0d expected 1", uncorr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = n_popped;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    chk_en    = 1'b1;
    data_in   = 32'hA5A5_0001;
    chk_in    = parity(data_in);
    tick();
    data_in   = 32'h1234_5678;
    chk_in    = parity(data_in) ^ 6'h04;
    tick();
    data_in   = 32'hFFFF_0000;
    chk_in    = 6'h3F;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_backpressure: got in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
    end
    for (int k = 0; k < 5; k++) tick();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (last_acc) break;
    end
    drain();
    n_checks++;
    if (n_popped - p0 != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d words expected 3", n_popped - p0);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      chk_en    = ($urandom_range(0, 7) != 0);
      d = $urandom;
      c = parity(d);
      case ($urandom_range(0, 4))
        0: ;
        1: d = d ^ (DW'(1) << $urandom_range(0, DW - 1));
        2: c = c ^ (CW'(1) << $urandom_range(0, CW - 1));
        3: d = d ^ (DW'(1) << $urandom_range(0, 15)) ^ (DW'(1) << $urandom_range(16, DW - 1));
        default: c = CW'($urandom);
      endcase
      data_in = d;
      chk_in  = c;
      tick();
    end
    cnt_clr = 1'b0;
    drain();
  endtask

  task automatic test_saturation();
    logic [DW-1:0] d;
    cnt_clr = 1'b1;
    tick();
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    chk_en    = 1'b1;
    for (int k = 0; k < (1 << NW) + 3; k++) begin
      d       = $urandom;
      chk_in  = parity(d);
      data_in = d ^ (DW'(1) << $urandom_range(0, DW - 1));
      tick();
    end
    drain();
    n_checks++;
    if (corr_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL corr_saturate: got %h expected ffff", corr_cnt);
    end
    send(32'h0000_0010, '0, 1'b1);
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_checks++;
    if (corr_cnt !== '0) begin
      n_fail++;
      $display("FAIL clr_wins: got %0d expected 0", corr_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    chk_en    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_in = $urandom;
      chk_in  = parity(data_in);
      tick();
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || err_corr !== 1'b0 || err_uncorr !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got v=%b c=%b u=%b expected 0/0/0", out_valid, err_corr, err_uncorr);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_flush: got out_valid=%b expected 0", out_valid);
    end
    send(32'hFFFF_FFFF, parity(32'hFFFF_FFFF), 1'b1);
    tick();
    n_checks++;
    if (data_out !== 32'hFFFF_FFFF || err_corr !== 1'b0 || err_uncorr !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_word: got d=%h c=%b u=%b expected ffffffff/0/0",
               data_out, err_corr, err_uncorr);
    end
    drain();
  endtask

`ifdef SEC_KEYLOCK_EN
  task automatic test_keylock();
    in_valid  = 1'b0;
    key_shift = 1'b1;
    key_sin   = 1'b1;
    for (int k = 0; k < DW; k++) tick();
    key_shift = 1'b0;
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, '0, 1'b1);
    tick();
    n_checks++;
    if (data_out !== 32'hFFFF_FFFF || err_corr !== 1'b0 || err_uncorr !== 1'b0) begin
      n_fail++;
      $display("FAIL keylock_word: got d=%h c=%b u=%b expected ffffffff/0/0",
               data_out, err_corr, err_uncorr);
    end
    drain();
    key_shift = 1'b1;
    for (int k = 0; k < DW; k++) begin
      key_sin = 1'($urandom);
      tick();
    end
    key_shift = 1'b0;
    for (int k = 0; k < 40; k++) begin
      in_valid  = 1'b1;
      out_ready = ($urandom_range(0, 2) != 0);
      data_in   = $urandom;
      chk_in    = ($urandom_range(0, 1) != 0) ? parity(data_in) : CW'($urandom);
      tick();
    end
    drain();
  endtask
`endif

  initial begin
    build_cols();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    chk_in    = '0;
    chk_en    = 1'b1;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
`ifdef SEC_KEYLOCK_EN
    key_sin   = 1'b0;
    key_shift = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_clean();
    test_single_err();
    test_uncorr();
    test_back_to_back();
    test_random();
    test_saturation();
`ifdef SEC_KEYLOCK_EN
    test_keylock();
`endif
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sec_decoder_pipe.md
SEC_DECODER_PIPE -- requirements
Module: sec_decoder_pipe

Interface
REQ-001 Parameter DATA_W, default 32: data word width, range 4..64.
REQ-002 Parameter CHK_W, default 6: check-bit width; DATA_W SHALL be no greater than 2^CHK_W - CHK_W - 1, otherwise elaboration fails.
REQ-003 Parameter CNT_W, default 16: width of the event counters.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  input word present.
REQ-007 in_ready  out  1  block accepts the input word this cycle.
REQ-008 data_in  in  DATA_W  received data bits.
REQ-009 chk_in  in  CHK_W  received check bits.
REQ-010 chk_en  in  1  0 disables correction (pass-through), sampled with the word.
REQ-011 out_valid  out  1  output word present.
REQ-012 out_ready  in  1  downstream accepts.
REQ-013 data_out  out  DATA_W  corrected data.
REQ-014 err_corr  out  1  single error corrected (data or check bit).
REQ-015 err_uncorr  out  1  syndrome matches no column.
REQ-016 corr_cnt, uncorr_cnt  out  CNT_W each  saturating event counters.
REQ-017 cnt_clr  in  1  synchronous counter clear pulse.

Function
REQ-018 Column code col(i) for data bit i SHALL be the i-th (0-based) integer >=3, ascending, that is not a power of two (col(0)=3, col(1)=5, col(2)=6, col(3)=7, col(4)=9, col(31)=38).
REQ-019 Computed parity p[j] SHALL be the XOR of data bits i with col(i) bit j set; syndrome s = chk_in XOR p.
REQ-020 chk_en=0 SHALL force s=0.
REQ-021 s=0: data passes, no flag; s a power of two: data passes, err_corr=1; s=col(i): data bit i inverted, err_corr=1; any other s: data passes unmodified, err_uncorr=1.
REQ-022 Two-stage pipeline: stage 1 registers data, chk_en and syndrome; stage 2 registers data_out and flags; latency exactly 2 accepted-advance cycles.
REQ-023 advance = !out_valid OR out_ready; in_ready = advance; both stages shift only when advance=1; bubbles are not collapsed.
REQ-024 While out_ready=0 and out_valid=1, data_out, err_corr and err_uncorr SHALL hold stable.
REQ-025 A word is accepted when in_valid AND in_ready; out_valid SHALL mirror stage-2 occupancy.
REQ-026 Counters increment by 1 on out_valid AND out_ready with the matching flag; they saturate at 2^CNT_W-1.
REQ-027 cnt_clr coincident with an increment: clear wins, counter = 0.
REQ-028 Flags outside out_valid=1 SHALL be 0.

Reset
REQ-029 rst_n=0 at a clock edge: both stage-valid bits, out_valid, err_corr, err_uncorr, data_out, corr_cnt, uncorr_cnt SHALL become 0; in-flight words are discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-031 Macro SEC_KEYLOCK_EN defined: ports key_sin (in, 1) and key_shift (in, 1) SHALL exist; DATA_W-bit key_reg, reset 0, shifts left on key_shift with key_sin into bit 0.
REQ-032 With SEC_KEYLOCK_EN: stage 1 captures data_in XOR key_reg, and stage 2 outputs corrected data XOR key_reg, each using key_reg as it is in that capture cycle.
REQ-033 Without SEC_KEYLOCK_EN: key ports absent, behaviour identical to key_reg=0.

Verification
REQ-034 data_in=0, chk_in=0, chk_en=1, out_ready=1 -> data_out=0 two cycles later, no flags, counters unchanged.
REQ-035 data_in=0x00000001, chk_in=0 -> s=3, data_out=0, err_corr=1, corr_cnt=1; chk_in=0x01 with data 0 -> data_out=0, err_corr=1, corr_cnt=2.
REQ-036 data_in=0, chk_in=0x3F -> err_uncorr=1, data_out=0, uncorr_cnt=1; repeat with chk_en=0 -> no flag.
REQ-037 Three words sent back-to-back, out_ready=0 for 5 cycles -> in_ready=0 after two words are held, data_out stable, all three words delivered in order once out_ready=1.
REQ-038 cnt_clr asserted together with a correcting output handshake -> corr_cnt=0; counter preloaded by 2^CNT_W+3 errors -> value 0xFFFF.
REQ-039 SEC_KEYLOCK_EN: shift in 32 ones, data_in=0xFFFFFFFF, chk_in=0 -> data_out=0xFFFFFFFF, no flags; reset mid-stream -> out_valid=0 next cycle, key_reg=0.
